cmsdk_uart_capture_mc: RTL and testbench

Multi-channel, parametrised UART capture monitor for the MCU system testbench and simulation harness.
- Receives NUM_CH independent serial lines, e.g. UART0/1/2 TXD from the GPIO alternate functions.
- Reports each received byte with framing and parity status.
- Decodes the escape-command protocol on channel 0 to drive the debug-tester enable, simulation-end and auxiliary control outputs.
- Generalises the single-channel, fixed-format capture block in channel count, data width, parity and baud divisor.

---
 rtl/cmsdk_uart_capture_pkg.sv | 20 ++
 rtl/cmsdk_uart_capture_rx.sv | 106 ++++++++++
 rtl/cmsdk_uart_capture_mc.sv | 99 +++++++++
 tb/tb_cmsdk_uart_capture_mc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_uart_capture_pkg.sv
// Shared types and constants for the multi-channel UART capture monitor:
// receiver states, escape-command codes and parity modes.
package cmsdk_uart_capture_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  typedef enum logic {NORMAL, ESC} esc_state_t;

  localparam logic [7:0] ESC_CODE    = 8'h1B;
  localparam logic [7:0] CMD_DBG_EN  = 8'h11;
  localparam logic [7:0] CMD_DBG_DIS = 8'h12;
  localparam logic [7:0] CMD_SIM_END = 8'h04;
  // Upper-nibble matches; the lower nibble carries the AUXCTRL payload.
  localparam logic [3:0] CMD_AUX_LO  = 4'h2;
  localparam logic [3:0] CMD_AUX_HI  = 4'h3;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/cmsdk_uart_capture_rx.sv
// Single-channel UART receiver: 2-flop input synchroniser, mid-bit sampling
// counter and frame FSM reporting good bytes, framing and parity errors.
module cmsdk_uart_capture_rx
  import cmsdk_uart_capture_pkg::*;
#(
  parameter int BAUD_DIV  = 16,
  parameter int DATA_BITS = 8,
  parameter int PAR_MODE  = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [DATA_BITS-1:0] data
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);

  logic                 rxd_p0, rxd_p1;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic                 par_bad;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0     <= 1'b1;
      rxd_p1     <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      par_bad    <= 1'b0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      data       <= '0;
    end else begin
      rxd_p0     <= rxd;
      rxd_p1     <= rxd_p0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: if (!rxd_p1) begin
          cnt   <= HALF_LOAD;
          state <= START;
        end
        START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rxd_p1) state <= IDLE;
          else begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            par_bad <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= (PAR_MODE != PAR_NONE) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            // Odd mode wants the XOR over data+parity to be 1, even mode 0.
            par_bad <= ((^shreg) ^ rxd_p1) != (PAR_MODE == PAR_ODD);
            cnt     <= FULL_LOAD;
            state   <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!rxd_p1) begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end else begin
            if (par_bad) parity_err <= 1'b1;
            else begin
              valid <= 1'b1;
              data  <= shreg;
            end
            state <= IDLE;
          end
        end
        BREAK: if (rxd_p1) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data shift register carries no reset; it is only observed after a full frame.
  always_ff @(posedge clk) begin
    if (state == DATA && cnt == '0) shreg <= {rxd_p1, shreg[DATA_BITS-1:1]};
  end

endmodule

// File: rtl/cmsdk_uart_capture_mc.sv
// Multi-channel UART capture monitor with channel-0 escape-command decoder.
// Optional simulation line printer enabled by CMSDK_UART_CAPTURE_PRINT_EN.
module cmsdk_uart_capture_mc
  import cmsdk_uart_capture_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int BAUD_DIV  = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic [NUM_CH-1:0]             RXD,
  output logic [NUM_CH-1:0]             RX_VALID,
  output logic [NUM_CH*DATA_BITS-1:0]   RX_DATA,
  output logic [NUM_CH-1:0]             RX_FRAME_ERR,
  output logic [NUM_CH-1:0]             RX_PARITY_ERR,
  output logic                          DEBUG_TESTER_ENABLE,
  output logic                          SIMULATIONEND,
  output logic [7:0]                    AUXCTRL
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rx
    cmsdk_uart_capture_rx #(
      .BAUD_DIV (BAUD_DIV),
      .DATA_BITS(DATA_BITS),
      .PAR_MODE (PARITY)
    ) u_rx (
      .clk       (CLK),
      .rst_n     (RESETn),
      .rxd       (RXD[g]),
      .valid     (RX_VALID[g]),
      .frame_err (RX_FRAME_ERR[g]),
      .parity_err(RX_PARITY_ERR[g]),
      .data      (RX_DATA[g*DATA_BITS +: DATA_BITS])
    );
  end

  esc_state_t esc_state;
  logic [7:0] byte0;

  assign byte0 = 8'(RX_DATA[DATA_BITS-1:0]);

  // Decoder sees only good channel-0 bytes, so errored frames never act.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      esc_state           <= NORMAL;
      DEBUG_TESTER_ENABLE <= 1'b0;
      SIMULATIONEND       <= 1'b0;
      AUXCTRL             <= 8'h00;
    end else if (RX_VALID[0]) begin
      case (esc_state)
        NORMAL: if (byte0 == ESC_CODE) esc_state <= ESC;
        ESC: begin
          esc_state <= NORMAL;
          if (byte0 == CMD_DBG_EN)            DEBUG_TESTER_ENABLE <= 1'b1;
          else if (byte0 == CMD_DBG_DIS)      DEBUG_TESTER_ENABLE <= 1'b0;
          else if (byte0 == CMD_SIM_END)      SIMULATIONEND       <= 1'b1;
          else if (byte0[7:4] == CMD_AUX_LO)  AUXCTRL[3:0]        <= byte0[3:0];
          else if (byte0[7:4] == CMD_AUX_HI)  AUXCTRL[7:4]        <= byte0[3:0];
        end
        default: esc_state <= NORMAL;
      endcase
    end
  end

`ifdef CMSDK_UART_CAPTURE_PRINT_EN
  logic [7:0] pbuf [NUM_CH][128];
  int         plen [NUM_CH];

  // esc_state here is the pre-update value, matching what the decoder consumes.
  always @(posedge CLK) begin
    if (!RESETn) begin
      for (int c = 0; c < NUM_CH; c++) plen[c] = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (RX_VALID[c]) begin
          logic [7:0] b;
          string      s;
          b = 8'(RX_DATA[c*DATA_BITS +: DATA_BITS]);
          if (!(c == 0 && (esc_state == ESC || b == ESC_CODE)) && b != 8'h0D) begin
            if (b != 8'h0A) begin
              pbuf[c][plen[c]] = b;
              plen[c]++;
            end
            if (b == 8'h0A || plen[c] == 128) begin
              s = "";
              for (int i = 0; i < plen[c]; i++) s = $sformatf("%s%c", s, pbuf[c][i]);
              $display("UART%0d @%0t: %s", c, $time, s);
              plen[c] = 0;
            end
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmsdk_uart_capture_mc.sv
// Directed bench for cmsdk_uart_capture_mc: 3-channel 8N1 instance plus a
// single-channel even-parity instance, checked with immediate assertions.
module tb_cmsdk_uart_capture_mc;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_p;
  logic [2:0]  rxd;
  logic [0:0]  rxd_p;
  int          cyc = 0;

  logic [2:0]  rx_valid, frame_err, parity_err;
  logic [23:0] rx_data;
  logic        dte, simend;
  logic [7:0]  aux;

  logic [0:0]  p_valid, p_ferr, p_perr;
  logic [7:0]  p_data;
  logic        p_dte, p_simend;
  logic [7:0]  p_aux;

  int checks = 0;
  int errors = 0;

  int vcnt [3] = '{0, 0, 0};
  int fcnt [3] = '{0, 0, 0};
  int pcnt [3] = '{0, 0, 0};
  int vcyc [3] = '{0, 0, 0};
  int pv_cnt = 0, pp_cnt = 0, pf_cnt = 0, pv_cyc = 0;
  logic dte_q = 1'b0;
  int   dte_rise = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmsdk_uart_capture_mc #(.NUM_CH(3), .BAUD_DIV(16), .DATA_BITS(8), .PARITY(0)) u_dut (
    .CLK(clk), .RESETn(rst_n), .RXD(rxd),
    .RX_VALID(rx_valid), .RX_DATA(rx_data), .RX_FRAME_ERR(frame_err),
    .RX_PARITY_ERR(parity_err), .DEBUG_TESTER_ENABLE(dte),
    .SIMULATIONEND(simend), .AUXCTRL(aux)
  );

  cmsdk_uart_capture_mc #(.NUM_CH(1), .BAUD_DIV(16), .DATA_BITS(8), .PARITY(2)) u_par (
    .CLK(clk), .RESETn(rst_n_p), .RXD(rxd_p),
    .RX_VALID(p_valid), .RX_DATA(p_data), .RX_FRAME_ERR(p_ferr),
    .RX_PARITY_ERR(p_perr), .DEBUG_TESTER_ENABLE(p_dte),
    .SIMULATIONEND(p_simend), .AUXCTRL(p_aux)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid[i]) begin
        vcnt[i] <= vcnt[i] + 1;
        vcyc[i] <= cyc;
      end
      if (frame_err[i])  fcnt[i] <= fcnt[i] + 1;
      if (parity_err[i]) pcnt[i] <= pcnt[i] + 1;
    end
    if (p_valid[0]) begin
      pv_cnt <= pv_cnt + 1;
      pv_cyc <= cyc;
    end
    if (p_perr[0]) pp_cnt <= pp_cnt + 1;
    if (p_ferr[0]) pf_cnt <= pf_cnt + 1;
    dte_q <= dte;
    if (dte && !dte_q) dte_rise <= cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame bit by bit (start, data LSB first, optional parity, stop);
  // the line is left at the stop value. Call at #1 after a rising edge.
  task automatic send(input int dut, input int ch, input logic [7:0] b,
                      input bit with_par, input logic par_bit, input logic stop);
    logic [10:0] bits;
    int          n;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    n = 9;
    if (with_par) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = stop;
    n++;
    for (int i = 0; i < n; i++) begin
      if (dut == 0) rxd[ch] = bits[i];
      else          rxd_p[0] = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic tx0(input logic [7:0] b);
    send(0, 0, b, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0, v0, v1, v2, f2, p0, f0, pv, pp;

    rst_n = 1'b0; rst_n_p = 1'b0;
    rxd = 3'b111; rxd_p = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {61'd0, rx_valid}, 64'd0);
    chk("reset_data", {40'd0, rx_data}, 64'd0);
    chk("reset_ctrl", {54'd0, dte, simend, aux}, 64'd0);
    rst_n = 1'b1; rst_n_p = 1'b1;

    // Idle line for 1000 cycles: nothing may happen.
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_pulses", 64'(vcnt[0] + vcnt[1] + vcnt[2] + fcnt[0] + fcnt[1] + fcnt[2]
                           + pcnt[0] + pcnt[1] + pcnt[2] + pv_cnt + pp_cnt + pf_cnt), 64'd0);
    chk("idle_data", {40'd0, rx_data}, 64'd0);
    chk("idle_ctrl", {54'd0, dte, simend, aux}, 64'd0);

    // Overlapped frames on ch0 and ch1 (ch1 starts 5 cycles later).
    s0 = cyc; v0 = vcnt[0]; v1 = vcnt[1];
    fork
      send(0, 0, 8'h41, 1'b0, 1'b0, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        send(0, 1, 8'h5A, 1'b0, 1'b0, 1'b1);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("ovl_cnt0", 64'(vcnt[0] - v0), 64'd1);
    chk("ovl_cnt1", 64'(vcnt[1] - v1), 64'd1);
    chk("ovl_cyc0", 64'(vcyc[0]), 64'(s0 + 155));
    chk("ovl_cyc1", 64'(vcyc[1]), 64'(s0 + 160));
    chk("ovl_data0", {56'd0, rx_data[7:0]}, 64'h41);
    chk("ovl_data1", {56'd0, rx_data[15:8]}, 64'h5A);

    // Ch2: bad stop bit, line held low 30 bit times, recovery, then 0x55.
    v2 = vcnt[2]; f2 = fcnt[2];
    send(0, 2, 8'h33, 1'b0, 1'b0, 1'b0);
    repeat (480) @(posedge clk);
    #1;
    rxd[2] = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    chk("brk_ferr", 64'(fcnt[2] - f2), 64'd1);
    chk("brk_novalid", 64'(vcnt[2] - v2), 64'd0);
    chk("brk_data_kept", {56'd0, rx_data[23:16]}, 64'h00);
    send(0, 2, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("brk_valid55", 64'(vcnt[2] - v2), 64'd1);
    chk("brk_data55", {56'd0, rx_data[23:16]}, 64'h55);
    chk("brk_ferr_once", 64'(fcnt[2] - f2), 64'd1);

    // 4-cycle low glitch on ch0 must be rejected as a false start.
    v0 = vcnt[0]; f0 = fcnt[0]; p0 = pcnt[0];
    rxd[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd[0] = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_pulses", 64'((vcnt[0] - v0) + (fcnt[0] - f0) + (pcnt[0] - p0)), 64'd0);
    chk("glitch_data", {56'd0, rx_data[7:0]}, 64'h41);

    // Escape-command decoding on channel 0.
    tx0(8'h1B); tx0(8'h11);
    chk("esc_data11_after_glitch", {56'd0, rx_data[7:0]}, 64'h11);
    chk("esc_dbg_en", {63'd0, dte}, 64'd1);
    chk("esc_dbg_timing", 64'(dte_rise), 64'(vcyc[0] + 1));
    tx0(8'h1B); tx0(8'h12);
    chk("esc_dbg_dis", {63'd0, dte}, 64'd0);
    tx0(8'h1B); tx0(8'h25);
    tx0(8'h1B); tx0(8'h3A);
    chk("esc_aux_a5", {56'd0, aux}, 64'hA5);
    tx0(8'h1B); tx0(8'h41);
    chk("esc_aux_keep", {56'd0, aux}, 64'hA5);
    tx0(8'h11);
    chk("noesc_dbg", {63'd0, dte}, 64'd0);
    tx0(8'h1B); tx0(8'h2F);
    chk("esc_aux_lo_f", {56'd0, aux}, 64'hAF);
    chk("simend_pre", {63'd0, simend}, 64'd0);
    tx0(8'h1B); tx0(8'h04);
    chk("simend_set", {63'd0, simend}, 64'd1);
    tx0(8'h1B); tx0(8'h12);
    repeat (100) @(posedge clk);
    #1;
    chk("simend_sticky", {63'd0, simend}, 64'd1);

    // Even parity instance: good 0x07 (parity 1), then 0x03 with wrong parity 1.
    s0 = cyc; pv = pv_cnt; pp = pp_cnt;
    send(1, 0, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("par_good_cnt", 64'(pv_cnt - pv), 64'd1);
    chk("par_good_cyc", 64'(pv_cyc), 64'(s0 + 171));
    chk("par_good_data", {56'd0, p_data}, 64'h07);
    send(1, 0, 8'h03, 1'b1, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("par_err_cnt", 64'(pp_cnt - pp), 64'd1);
    chk("par_err_novalid", 64'(pv_cnt - pv), 64'd1);
    chk("par_err_data", {56'd0, p_data}, 64'h07);

    // Reset in the middle of a frame, then a clean 0x5A (even parity bit 0).
    rxd_p[0] = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    rst_n_p = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_outs", {54'd0, p_valid, p_ferr, p_perr, p_data}, 64'd0);
    chk("midrst_ctrl", {54'd0, p_dte, p_simend, p_aux}, 64'd0);
    rxd_p[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n_p = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    pv = pv_cnt; pp = pp_cnt;
    send(1, 0, 8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_cnt", 64'(pv_cnt - pv), 64'd1);
    chk("post_rst_data", {56'd0, p_data}, 64'h5A);
    chk("post_rst_nopar", 64'(pp_cnt - pp), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
